// File: rtl/pipe_pkg.sv
// Shared types and constants for the 8-bit, 8-register pipelined datapath.
package pipe_pkg;

    localparam int DW = 8;
    localparam int AW = 3;

    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,
        FWD_EXWB = 2'b01,
        FWD_HIST = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] result;
        logic          we;
    } wb_bus_t;

endpackage

// File: rtl/ex_wb_stage_fwd_unit.sv
// Combinational operand forwarding: picks the newest pending write to rs,
// falling back to the register-file value captured in ID.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [AW-1:0] rs_i,
    input  logic [DW-1:0] rf_data_i,
    input  wb_bus_t       exwb_i,
    input  wb_bus_t       hist_i,
    output fwd_sel_t      sel_o,
    output logic [DW-1:0] op_o
);

    always_comb begin
        sel_o = FWD_RF;
        op_o  = rf_data_i;
        // EX/WB is checked first so the younger write shadows the history entry.
        if (exwb_i.we && (exwb_i.rd == rs_i)) begin
            sel_o = FWD_EXWB;
            op_o  = exwb_i.result;
        end else if (hist_i.we && (hist_i.rd == rs_i)) begin
            sel_o = FWD_HIST;
            op_o  = hist_i.result;
        end
    end

endmodule

// File: rtl/ex_wb_stage.sv
// Execute stage and EX/WB register with two-deep writeback forwarding.
// Optional zero/carry flag outputs are built when EX_FLAGS_EN is defined.
module ex_wb_stage
    import pipe_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic [AW-1:0] rd,
    input  logic [DW-1:0] ext_data,
    input  logic [DW-1:0] data1,
    input  logic [DW-1:0] data2,
    input  logic          regwrite,
    input  logic          wbsel,
    output logic [AW-1:0] rdout,
    output logic [DW-1:0] resultout,
    output logic          regwriteout,
    output logic [1:0]    fwd1out,
    output logic [1:0]    fwd2out
`ifdef EX_FLAGS_EN
    ,
    output logic          zflagout,
    output logic          cflagout
`endif
);

    wb_bus_t       exwb_q, exwb_d;
    wb_bus_t       hist_q, hist_d;
    fwd_sel_t      fwd1_q, fwd1_d;
    fwd_sel_t      fwd2_q, fwd2_d;
    fwd_sel_t      sel1, sel2;
    logic [DW-1:0] op1, op2;
    logic [DW-1:0] sum;
    logic [DW-1:0] result;

    fwd_unit u_fwd1 (
        .rs_i      (rs1),
        .rf_data_i (data1),
        .exwb_i    (exwb_q),
        .hist_i    (hist_q),
        .sel_o     (sel1),
        .op_o      (op1)
    );

    fwd_unit u_fwd2 (
        .rs_i      (rs2),
        .rf_data_i (data2),
        .exwb_i    (exwb_q),
        .hist_i    (hist_q),
        .sel_o     (sel2),
        .op_o      (op2)
    );

`ifdef EX_FLAGS_EN
    logic carry;
    logic zflag_q, zflag_d;
    logic cflag_q, cflag_d;

    always_comb begin
        {carry, sum} = {1'b0, op1} + {1'b0, op2};
    end
`else
    always_comb begin
        sum = op1 + op2;
    end
`endif

    always_comb begin
        result = wbsel ? ext_data : sum;
    end

    always_comb begin
        exwb_d = exwb_q;
        hist_d = hist_q;
        fwd1_d = fwd1_q;
        fwd2_d = fwd2_q;
`ifdef EX_FLAGS_EN
        zflag_d = zflag_q;
        cflag_d = cflag_q;
`endif
        // A flush still ages the retiring write so it stays forwardable.
        if (flush) begin
            hist_d = exwb_q;
            exwb_d = '0;
            fwd1_d = FWD_RF;
            fwd2_d = FWD_RF;
`ifdef EX_FLAGS_EN
            zflag_d = 1'b0;
            cflag_d = 1'b0;
`endif
        end else if (!stall) begin
            hist_d        = exwb_q;
            exwb_d.rd     = rd;
            exwb_d.result = result;
            exwb_d.we     = regwrite;
            fwd1_d        = sel1;
            fwd2_d        = sel2;
`ifdef EX_FLAGS_EN
            zflag_d = (result == '0);
            cflag_d = carry & ~wbsel;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exwb_q <= '0;
            hist_q <= '0;
            fwd1_q <= FWD_RF;
            fwd2_q <= FWD_RF;
`ifdef EX_FLAGS_EN
            zflag_q <= 1'b0;
            cflag_q <= 1'b0;
`endif
        end else begin
            exwb_q <= exwb_d;
            hist_q <= hist_d;
            fwd1_q <= fwd1_d;
            fwd2_q <= fwd2_d;
`ifdef EX_FLAGS_EN
            zflag_q <= zflag_d;
            cflag_q <= cflag_d;
`endif
        end
    end

    assign rdout       = exwb_q.rd;
    assign resultout   = exwb_q.result;
    assign regwriteout = exwb_q.we;
    assign fwd1out     = fwd1_q;
    assign fwd2out     = fwd2_q;
`ifdef EX_FLAGS_EN
    assign zflagout = zflag_q;
    assign cflagout = cflag_q;
`endif

endmodule

// File: tb/tb_ex_wb_stage.sv
// Bench for ex_wb_stage: directed literal sequences followed by randomized
// traffic, with every cycle compared against a queue-based writeback log model.
module tb_ex_wb_stage;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic [AW-1:0] rs1 = '0, rs2 = '0, rd = '0;
    logic [DW-1:0] ext_data = '0, data1 = '0, data2 = '0;
    logic          regwrite = 1'b0;
    logic          wbsel = 1'b0;
    logic [AW-1:0] rdout;
    logic [DW-1:0] resultout;
    logic          regwriteout;
    logic [1:0]    fwd1out, fwd2out;
`ifdef EX_FLAGS_EN
    logic          zflagout, cflagout;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    ex_wb_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .ext_data    (ext_data),
        .data1       (data1),
        .data2       (data2),
        .regwrite    (regwrite),
        .wbsel       (wbsel),
        .rdout       (rdout),
        .resultout   (resultout),
        .regwriteout (regwriteout),
        .fwd1out     (fwd1out),
        .fwd2out     (fwd2out)
`ifdef EX_FLAGS_EN
        ,
        .zflagout    (zflagout),
        .cflagout    (cflagout)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    // behavioural model: log of retired writes, newest first
    typedef struct {
        int rd;
        int val;
        bit we;
    } wr_t;

    wr_t log_q[$];
    int  e_fwd1 = 0, e_fwd2 = 0;
    bit  e_z = 0, e_c = 0;

    function automatic int lookup(input int rs, input int rf_val, output int sel);
        sel = 0;
        for (int i = 0; i < 2 && i < log_q.size(); i++) begin
            if (log_q[i].we && log_q[i].rd == rs) begin
                sel = (i == 0) ? 1 : 2;
                return log_q[i].val;
            end
        end
        return rf_val;
    endfunction

    task automatic retire(input wr_t w);
        log_q.push_front(w);
        while (log_q.size() > 2) void'(log_q.pop_back());
    endtask

    always @(posedge clk) begin
        wr_t w;
        int  a, b, s1, s2, full;
        if (rst) begin
            log_q.delete();
            w = '{rd: 0, val: 0, we: 0};
            retire(w);
            retire(w);
            e_fwd1 = 0; e_fwd2 = 0; e_z = 0; e_c = 0;
        end else if (flush) begin
            w = '{rd: 0, val: 0, we: 0};
            retire(w);
            e_fwd1 = 0; e_fwd2 = 0; e_z = 0; e_c = 0;
        end else if (!stall) begin
            a = lookup(int'(rs1), int'(data1), s1);
            b = lookup(int'(rs2), int'(data2), s2);
            full = a + b;
            w.rd  = int'(rd);
            w.val = wbsel ? int'(ext_data) : (full % 256);
            w.we  = regwrite;
            e_z = (w.val == 0);
            e_c = !wbsel && (full > 255);
            retire(w);
            e_fwd1 = s1; e_fwd2 = s2;
        end
    end

    // scoreboard
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // compare process: every cycle once reset has been applied
    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_rdout", int'(rdout), log_q[0].rd);
            check("mdl_result", int'(resultout), log_q[0].val);
            check("mdl_we", int'(regwriteout), int'(log_q[0].we));
            check("mdl_fwd1", int'(fwd1out), e_fwd1);
            check("mdl_fwd2", int'(fwd2out), e_fwd2);
`ifdef EX_FLAGS_EN
            check("mdl_z", int'(zflagout), int'(e_z));
            check("mdl_c", int'(cflagout), int'(e_c));
`endif
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input int r1, input int d1, input int r2, input int d2,
                         input int dst, input int ext, input bit we, input bit ws);
        rs1 = AW'(r1); data1 = DW'(d1);
        rs2 = AW'(r2); data2 = DW'(d2);
        rd = AW'(dst); ext_data = DW'(ext);
        regwrite = we; wbsel = ws;
        step();
    endtask

    task automatic expect_out(input string tag, input int erd, input int eres,
                              input int ewe, input int ef1, input int ef2);
        check({tag, "_rd"}, int'(rdout), erd);
        check({tag, "_res"}, int'(resultout), eres);
        check({tag, "_we"}, int'(regwriteout), ewe);
        check({tag, "_f1"}, int'(fwd1out), ef1);
        check({tag, "_f2"}, int'(fwd2out), ef2);
    endtask

    initial begin
        // reset with nonzero inputs
        rst = 1'b1;
        rs1 = 3'd1; rs2 = 3'd2; rd = 3'd5; data1 = 8'hAA; data2 = 8'h55;
        ext_data = 8'h11; regwrite = 1'b1; wbsel = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        expect_out("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        issue(6, 5, 6, 7, 3, 0, 1, 0);
        expect_out("first", 3, 12, 1, 0, 0);

        // back-to-back RAW
        issue(0, 0, 0, 0, 1, 10, 1, 1);
        issue(1, 0, 1, 0, 2, 0, 1, 0);
        expect_out("raw1", 2, 20, 1, 1, 1);

        // distance-2 RAW
        issue(0, 0, 0, 0, 1, 4, 1, 1);
        issue(6, 0, 7, 0, 5, 8'h33, 1, 1);
        issue(1, 0, 4, 1, 3, 0, 1, 0);
        expect_out("raw2", 3, 5, 1, 2, 0);

        // newer write wins over history
        issue(0, 0, 0, 0, 1, 4, 1, 1);
        issue(0, 0, 0, 0, 1, 9, 1, 1);
        issue(1, 0, 4, 0, 3, 0, 1, 0);
        expect_out("newest", 3, 9, 1, 1, 0);

        // wrap-around add
        issue(6, 8'hF0, 7, 8'h20, 5, 0, 1, 0);
        expect_out("wrap", 5, 8'h10, 1, 0, 0);
`ifdef EX_FLAGS_EN
        check("wrap_c", int'(cflagout), 1);
        check("wrap_z", int'(zflagout), 0);
`endif

        // regwrite=0 never forwards
        issue(0, 0, 0, 0, 6, 8'h55, 0, 1);
        issue(6, 8'h11, 2, 8'h01, 7, 0, 1, 0);
        expect_out("nowe", 7, 8'h12, 1, 0, 0);

        // stall freezes state; history must not age twice
        issue(0, 0, 0, 0, 1, 8'h40, 1, 1);
        stall = 1'b1;
        issue(0, 0, 0, 0, 2, 8'h77, 1, 1);
        step();
        step();
        expect_out("stall", 1, 8'h40, 1, 0, 0);
        stall = 1'b0;
        issue(7, 0, 1, 0, 2, 0, 1, 0);
        expect_out("unstall", 2, 8'h52, 1, 2, 1);

        // stall and flush together: bubble, old EX/WB ages
        stall = 1'b1; flush = 1'b1;
        issue(0, 0, 0, 0, 6, 8'h66, 1, 1);
        expect_out("flush", 0, 0, 0, 0, 0);
        stall = 1'b0; flush = 1'b0;
        issue(2, 0, 0, 3, 4, 0, 1, 0);
        expect_out("postflush", 4, 8'h55, 1, 2, 0);

        // reset during a dependent sequence
        issue(0, 0, 0, 0, 1, 8'h21, 1, 1);
        rst = 1'b1;
        issue(1, 5, 5, 1, 3, 0, 1, 0);
        check("midrst_we", int'(regwriteout), 0);
        rst = 1'b0;
        issue(1, 5, 5, 1, 3, 0, 1, 0);
        expect_out("postrst", 3, 6, 1, 0, 0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom_range(0, 99) < 3);
            flush = ($urandom_range(0, 99) < 10);
            stall = ($urandom_range(0, 99) < 15);
            issue($urandom_range(0, 7), $urandom_range(0, 255),
                  $urandom_range(0, 7), $urandom_range(0, 255),
                  $urandom_range(0, 7), $urandom_range(0, 255),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
        end
        rst = 1'b0; flush = 1'b0; stall = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
